mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (instruction fetch + data) onto one single-port memory.
// Data wins by default; a fetch stalled MaxWait cycles in a row is forced through.
module mem_port_arbiter #(
  parameter int AddrWidth = 15,
  parameter int DataWidth = 32,
  parameter int MaxWait   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ireq_i,
  input  logic [AddrWidth-1:0]   iaddr_i,
  output logic                   igrant_o,
  output logic                   irvalid_o,
  output logic [DataWidth-1:0]   irdata_o,
  input  logic                   dreq_i,
  input  logic [AddrWidth-1:0]   daddr_i,
  input  logic                   dwe_i,
  input  logic [DataWidth/8-1:0] dstrb_i,
  input  logic [DataWidth-1:0]   dwdata_i,
  output logic                   dgrant_o,
  output logic                   drvalid_o,
  output logic [DataWidth-1:0]   drdata_o,
  output logic                   mem_req_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_strb_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  output logic [31:0]            stall_cnt_o
);

  typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_e;

  owner_e      owner_q, owner_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] stall_q;
  logic        starve, igrant, dgrant, stalled;

  // Grants are purely combinational; reset masks them so nothing reaches memory.
  always_comb begin
    starve = (wait_q == 4'(MaxWait));
    igrant = 1'b0;
    dgrant = 1'b0;
    if (!rst_i) begin
      if (dreq_i && !(ireq_i && starve)) dgrant = 1'b1;
      else if (ireq_i)                   igrant = 1'b1;
    end
  end

  assign stalled = (ireq_i & ~igrant) | (dreq_i & ~dgrant);

  always_comb begin
    wait_d = 4'd0;
    if (ireq_i && !igrant)
      wait_d = starve ? wait_q : wait_q + 4'd1;
    owner_d = OWN_NONE;
    if (igrant)      owner_d = OWN_INSTR;
    else if (dgrant) owner_d = OWN_DATA;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q <= OWN_NONE;
      wait_q  <= 4'd0;
      stall_q <= 32'd0;
    end else begin
      owner_q <= owner_d;
      wait_q  <= wait_d;
      if (stalled && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_strb_o  = '0;
    mem_wdata_o = '0;
    if (igrant) begin
      mem_addr_o  = iaddr_i;
    end else if (dgrant) begin
      mem_addr_o  = daddr_i;
      mem_we_o    = dwe_i;
      mem_strb_o  = dstrb_i;
      mem_wdata_o = dwdata_i;
    end
  end

  assign igrant_o    = igrant;
  assign dgrant_o    = dgrant;
  assign mem_req_o   = igrant | dgrant;
  assign irvalid_o   = (owner_q == OWN_INSTR);
  assign drvalid_o   = (owner_q == OWN_DATA);
  assign irdata_o    = irvalid_o ? mem_rdata_i : '0;
  assign drdata_o    = drvalid_o ? mem_rdata_i : '0;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a stimulus process predicts grants and
// responses from the arbitration rules; a negedge monitor checks every response slot.
module tb_mem_port_arbiter;
  localparam int AW = 15, DW = 32, SW = 4, MW = 4;

  logic          clk = 1'b0, rst_i = 1'b1;
  logic          ireq_i = 0, dreq_i = 0, dwe_i = 0;
  logic [AW-1:0] iaddr_i = '0, daddr_i = '0;
  logic [SW-1:0] dstrb_i = '0;
  logic [DW-1:0] dwdata_i = '0, mem_rdata_i;
  logic          igrant_o, irvalid_o, dgrant_o, drvalid_o, mem_req_o, mem_we_o;
  logic [DW-1:0] irdata_o, drdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [SW-1:0] mem_strb_o;
  logic [31:0]   stall_cnt_o;

  mem_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaxWait(MW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ireq_i(ireq_i), .iaddr_i(iaddr_i), .igrant_o(igrant_o),
    .irvalid_o(irvalid_o), .irdata_o(irdata_o),
    .dreq_i(dreq_i), .daddr_i(daddr_i), .dwe_i(dwe_i), .dstrb_i(dstrb_i),
    .dwdata_i(dwdata_i), .dgrant_o(dgrant_o), .drvalid_o(drvalid_o), .drdata_o(drdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_strb_o(mem_strb_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int a);
    return (a == 16) ? 32'hDEAD_BEEF : (32'h0101_0101 * a) ^ 32'hA5A5_5A5A;
  endfunction

  // Environment memory: one-cycle read latency, old data returned on a write.
  logic [31:0] emem [256];
  logic [31:0] env_w;
  bit          env_ready = 0;
  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 256; i++) emem[i] = init_word(i);
      env_ready = 1;
    end
    if (mem_req_o) begin
      mem_rdata_i <= emem[mem_addr_o[7:0]];
      if (mem_we_o) begin
        env_w = emem[mem_addr_o[7:0]];
        for (int b = 0; b < SW; b++)
          if (mem_strb_o[b]) env_w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        emem[mem_addr_o[7:0]] = env_w;
      end
    end else begin
      mem_rdata_i <= $urandom;
    end
  end

  // Reference state
  logic [31:0] mmem [256];
  int          istall = 0;
  longint      m_stall = 0;
  typedef struct { int cyc; logic [31:0] data; } resp_t;
  resp_t iq[$], dq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (iq.size() > 0 && iq[0].cyc == cyc) begin
      chk("irvalid", 64'(irvalid_o), 64'd1);
      chk("irdata", 64'(irdata_o), 64'(iq[0].data));
      void'(iq.pop_front());
    end else begin
      chk("irvalid", 64'(irvalid_o), 64'd0);
      chk("irdata_idle", 64'(irdata_o), 64'd0);
    end
    if (dq.size() > 0 && dq[0].cyc == cyc) begin
      chk("drvalid", 64'(drvalid_o), 64'd1);
      chk("drdata", 64'(drdata_o), 64'(dq[0].data));
      void'(dq.pop_front());
    end else begin
      chk("drvalid", 64'(drvalid_o), 64'd0);
      chk("drdata_idle", 64'(drdata_o), 64'd0);
    end
  end

  // One arbitration cycle: drive, predict, check, update the reference.
  task automatic step(input bit ir, input int ia, input bit dr, input int da, input bit we,
                      input logic [SW-1:0] st, input logic [DW-1:0] wd,
                      output bit gi, output bit gd);
    logic [AW-1:0] ea; logic ewe; logic [SW-1:0] est; logic [DW-1:0] ewd;
    logic [31:0] w;
    @(negedge clk); #1;
    ireq_i = ir; iaddr_i = AW'(ia); dreq_i = dr; daddr_i = AW'(da);
    dwe_i = we; dstrb_i = st; dwdata_i = wd;
    #1;
    gi = ir && (!dr || istall == MW);
    gd = dr && !gi;
    ea = '0; ewe = 0; est = '0; ewd = '0;
    if (gi) ea = AW'(ia);
    if (gd) begin ea = AW'(da); ewe = we; est = st; ewd = wd; end
    chk("grant_i_d_req", {61'd0, igrant_o, dgrant_o, mem_req_o}, {61'd0, gi, gd, gi | gd});
    chk("mem_addr", 64'(mem_addr_o), 64'(ea));
    chk("mem_we_strb", {59'd0, mem_we_o, mem_strb_o}, {59'd0, ewe, est});
    chk("mem_wdata", 64'(mem_wdata_o), 64'(ewd));
    chk("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
    if (gi) iq.push_back('{cyc + 1, mmem[ia]});
    if (gd) begin
      dq.push_back('{cyc + 1, mmem[da]});
      if (we) begin
        w = mmem[da];
        for (int b = 0; b < SW; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
        mmem[da] = w;
      end
    end
    istall = (ir && !gi) ? istall + 1 : 0;
    if ((ir && !gi) || (dr && !gd)) m_stall = (m_stall >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall + 1;
  endtask

  bit gi, gd, ip, dp, pwe;
  int pia, pda;
  logic [SW-1:0] pst;
  logic [DW-1:0] pwd;

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
    ireq_i = 1; dreq_i = 1;
    #12;
    chk("reset_grants", {61'd0, igrant_o, dgrant_o, mem_req_o}, 64'd0);
    chk("reset_stall", 64'(stall_cnt_o), 64'd0);
    chk("reset_valids", {62'd0, irvalid_o, drvalid_o}, 64'd0);
    @(negedge clk); rst_i = 0; ireq_i = 0; dreq_i = 0;

    // Data read of 0x10, then data write with partial strobes and read-back
    step(0, 0, 1, 16, 0, 4'hF, 32'h0, gi, gd);
    step(0, 0, 1, 32, 1, 4'h3, 32'h1234_5678, gi, gd);
    step(0, 0, 1, 32, 0, 4'h0, 32'h0, gi, gd);
    // Alternating single requests
    for (int k = 0; k < 4; k++)
      if (k % 2 == 0) step(1, 40 + k, 0, 0, 0, 0, 0, gi, gd);
      else            step(0, 0, 1, 50 + k, 0, 4'hF, 0, gi, gd);
    // Continuous contention: starvation guard rotates in the fetch
    for (int k = 0; k < 12; k++) step(1, 60 + k, 1, 80 + k, k[0], 4'hF, $urandom, gi, gd);

    // Reset while an instruction response is pending
    step(1, 7, 0, 0, 0, 0, 0, gi, gd);
    @(posedge clk); #1;
    rst_i = 1; ireq_i = 1; dreq_i = 1;
    #1;
    chk("rst_irvalid_async", 64'(irvalid_o), 64'd0);
    chk("rst_stall_async", 64'(stall_cnt_o), 64'd0);
    chk("rst_grants", {61'd0, igrant_o, dgrant_o, mem_req_o}, 64'd0);
    iq.delete(); dq.delete(); istall = 0; m_stall = 0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_hold_grants", {61'd0, igrant_o, dgrant_o, mem_req_o}, 64'd0);
    end
    @(negedge clk); #2; rst_i = 0; ireq_i = 0; dreq_i = 0;

    // Randomized traffic; requests held until granted
    ip = 0; dp = 0;
    repeat (400) begin
      if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; pia = $urandom_range(0, 255); end
      if (!dp && $urandom_range(0, 9) < 6) begin
        dp = 1; pda = $urandom_range(0, 255); pwe = $urandom_range(0, 1) == 1;
        pst = SW'($urandom); pwd = $urandom;
      end
      step(ip, pia, dp, pda, pwe, pst, pwd, gi, gd);
      if (gi) ip = 0;
      if (gd) dp = 0;
    end

    // Stall counter saturation
    step(1, 1, 1, 2, 0, 4'hF, 0, gi, gd);
    force dut.stall_q = 32'hFFFF_FFFD;
    #1 release dut.stall_q;
    m_stall = 64'hFFFF_FFFE;
    for (int k = 0; k < 6; k++) step(1, 3 + k, 1, 9 + k, 0, 4'hF, 0, gi, gd);
    chk("stall_saturated", 64'(stall_cnt_o), 64'hFFFF_FFFF);

    repeat (3) step(0, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("resp_queues_drained", 64'(iq.size() + dq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
